// File: rtl/mem_stage_sram.sv
// Memory stage with MEM/WB pipeline register.
// Each 32-bit load/store becomes two 16-bit SRAM half-word accesses (low
// half first). The stage holds ready low for the whole access, which freezes
// the upstream pipeline and its own MEM/WB register.
module mem_stage_sram #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               WB_en_in,
    input  logic [1:0]         MEM_Signal_in,
    input  logic [4:0]         Dest_in,
    input  logic [31:0]        ALU_result_in,
    input  logic [31:0]        reg2_in,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               WB_en_out,
    output logic               MEM_R_EN_out,
    output logic [4:0]         Dest_out,
    output logic [31:0]        ALU_result_out,
    output logic [31:0]        Mem_read_value_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter reload value: the counter runs down to zero over WAIT_CYCLES cycles.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t             state;
    logic [3:0]         cnt;
    logic [15:0]        rd_lo;
    logic [15:0]        rd_hi;

    logic               req;
    logic               is_write;
    logic               is_read;
    logic               last_cycle;
    logic [31:0]        byte_off;
    logic [SRAM_AW-2:0] word_idx;
    logic               unused_addr_bits;

    // A store wins when both control bits are set.
    assign req        = MEM_Signal_in[1] | MEM_Signal_in[0];
    assign is_write   = MEM_Signal_in[0];
    assign is_read    = MEM_Signal_in[1] & ~MEM_Signal_in[0];
    assign last_cycle = (cnt == 4'd0);

    // Word index relative to the data-memory base; wraps silently, no range check.
    assign byte_off         = ALU_result_in - 32'(BASE_ADDR);
    assign word_idx         = byte_off[SRAM_AW:2];
    assign unused_addr_bits = ^{byte_off[31:SRAM_AW+1], byte_off[1:0]};

    // Stall while a request waits in IDLE or an access is in flight.
    assign ready = !((state == IDLE && req) || state == LO || state == HI);

    // Access sequencer: IDLE -> LO -> HI -> DONE -> IDLE, capturing read halves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rd_lo <= 16'd0;
            rd_hi <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= LO;
                        cnt   <= CNT_LOAD;
                    end
                end
                LO: begin
                    if (last_cycle) begin
                        rd_lo <= sram_dq_in;
                        state <= HI;
                        cnt   <= CNT_LOAD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HI: begin
                    if (last_cycle) begin
                        rd_hi <= sram_dq_in;
                        state <= DONE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                // DONE never starts an access, so the held instruction cannot retrigger.
                DONE: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // SRAM bus drive: quiet outside LO/HI, write data only for stores.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = 16'd0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            LO: begin
                sram_addr = {word_idx, 1'b0};
                if (is_write) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = reg2_in[15:0];
                end
            end
            HI: begin
                sram_addr = {word_idx, 1'b1};
                if (is_write) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = reg2_in[31:16];
                end
            end
            default: begin
                sram_addr = '0;
            end
        endcase
    end

    // MEM/WB register: advances only with the rest of the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_en_out          <= 1'b0;
            MEM_R_EN_out       <= 1'b0;
            Dest_out           <= 5'd0;
            ALU_result_out     <= 32'd0;
            Mem_read_value_out <= 32'd0;
        end else if (ready) begin
            WB_en_out          <= WB_en_in;
            MEM_R_EN_out       <= MEM_Signal_in[1];
            Dest_out           <= Dest_in;
            ALU_result_out     <= ALU_result_in;
            Mem_read_value_out <= is_read ? {rd_hi, rd_lo} : 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: directed scenarios plus randomized loads/stores
// against a word-level memory model and a behavioural SRAM device.
module tb_mem_stage_sram;

    localparam int BASE  = 1024;
    localparam int W     = 2;
    localparam int AW    = 18;
    localparam int STALL = 1 + 2 * W;

    logic          clk;
    logic          rst;
    logic          WB_en_in;
    logic [1:0]    MEM_Signal_in;
    logic [4:0]    Dest_in;
    logic [31:0]   ALU_result_in;
    logic [31:0]   reg2_in;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic [15:0]   sram_dq_in;
    logic          sram_dq_oe;
    logic          sram_we_n;
    logic          WB_en_out;
    logic          MEM_R_EN_out;
    logic [4:0]    Dest_out;
    logic [31:0]   ALU_result_out;
    logic [31:0]   Mem_read_value_out;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_sram #(
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(W),
        .SRAM_AW    (AW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .WB_en_in          (WB_en_in),
        .MEM_Signal_in     (MEM_Signal_in),
        .Dest_in           (Dest_in),
        .ALU_result_in     (ALU_result_in),
        .reg2_in           (reg2_in),
        .ready             (ready),
        .sram_addr         (sram_addr),
        .sram_dq_out       (sram_dq_out),
        .sram_dq_in        (sram_dq_in),
        .sram_dq_oe        (sram_dq_oe),
        .sram_we_n         (sram_we_n),
        .WB_en_out         (WB_en_out),
        .MEM_R_EN_out      (MEM_R_EN_out),
        .Dest_out          (Dest_out),
        .ALU_result_out    (ALU_result_out),
        .Mem_read_value_out(Mem_read_value_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-on contents of the SRAM, as 32-bit words.
    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // SRAM device model: 1024 half-words, asynchronous read, write on clock edge.
    logic [15:0] sram_mem [0:1023];
    bit          written  [0:1023];
    int          wr_cycles = 0;
    logic [31:0] iw;

    always_comb begin
        iw         = init_word(int'(sram_addr[9:1]));
        sram_dq_in = sram_addr[0] ? iw[31:16] : iw[15:0];
        if (written[sram_addr[9:0]]) sram_dq_in = sram_mem[sram_addr[9:0]];
    end

    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram_mem[sram_addr[9:0]] <= sram_dq_out;
            written[sram_addr[9:0]]  <= 1'b1;
            wr_cycles                <= wr_cycles + 1;
        end
    end

    // Reference word memory, indexed by data-memory word number.
    logic [31:0] exp_mem [0:511];

    // Half-word SRAM address of a byte address.
    function automatic logic [AW-1:0] half_addr(input logic [31:0] alu, input bit h);
        logic [31:0] w;
        w = (alu - 32'(BASE)) >> 2;
        return {w[AW-2:0], h};
    endfunction

    // Expected SRAM drive in cycle c of a stall window (cycle 0 = request seen).
    function automatic void model_drive(input logic [1:0] sig, input logic [31:0] alu,
                                        input logic [31:0] r2, input int c,
                                        output logic [AW-1:0] ea, output logic ewe,
                                        output logic eoe, output logic [15:0] edq);
        bit h;
        ea = '0; ewe = 1'b1; eoe = 1'b0; edq = 16'd0;
        if (c >= 1) begin
            h  = (c > W);
            ea = half_addr(alu, h);
            if (sig[0]) begin
                ewe = 1'b0;
                eoe = 1'b1;
                edq = h ? r2[31:16] : r2[15:0];
            end
        end
    endfunction

    // Observations from the last transaction.
    int            stall_len;
    int            wr_delta;
    bit            first_low;
    logic [AW-1:0] tr_addr [0:63];
    logic [15:0]   tr_dq   [0:63];
    logic          tr_we   [0:63];
    logic          tr_oe   [0:63];

    // Present one instruction (called just after a rising edge), record the
    // stall window, then sample MEM/WB just after the edge that loads it.
    task automatic run_op(input logic wb, input logic [1:0] sig, input logic [4:0] dest,
                          input logic [31:0] alu, input logic [31:0] r2);
        bit done;
        int wr0;
        WB_en_in = wb; MEM_Signal_in = sig; Dest_in = dest;
        ALU_result_in = alu; reg2_in = r2;
        stall_len = 0; done = 0; first_low = 0; wr0 = wr_cycles;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (ready) begin
                done = 1;
            end else begin
                if (i == 0) first_low = 1;
                tr_addr[stall_len] = sram_addr;
                tr_dq[stall_len]   = sram_dq_out;
                tr_we[stall_len]   = sram_we_n;
                tr_oe[stall_len]   = sram_dq_oe;
                stall_len++;
                @(posedge clk);
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout: ready stayed low for %0d cycles, required release within %0d", stall_len, STALL);
        end
        @(posedge clk);
        #1;
        wr_delta = wr_cycles - wr0;
    endtask

    task automatic test_reset();
        rst = 1'b1; WB_en_in = 0; MEM_Signal_in = 0; Dest_in = 0;
        ALU_result_in = 0; reg2_in = 0;
        @(negedge clk);
        n_checks++;
        if ({ready, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out} !== {1'b1, 1'b1, 1'b0, 18'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_sram: got ready=%b we_n=%b oe=%b addr=%h dq=%h, required 1 1 0 0 0",
                     ready, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out);
        end
        n_checks++;
        if ({WB_en_out, MEM_R_EN_out, Dest_out, ALU_result_out, Mem_read_value_out} !== 71'd0) begin
            n_fail++;
            $display("FAIL reset_memwb: got wb=%b mr=%b dest=%0d alu=%h rv=%h, required all 0",
                     WB_en_out, MEM_R_EN_out, Dest_out, ALU_result_out, Mem_read_value_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        // Give MEM/WB non-zero contents so the mid-access clear is observable.
        run_op(1'b1, 2'b00, 5'd31, 32'hFFFF_0000, 32'd0);
        // Start a store to word 255 and reset during its HI phase.
        WB_en_in = 1; MEM_Signal_in = 2'b01; Dest_in = 5'd3;
        ALU_result_in = 32'd2044; reg2_in = 32'h1357_9BDF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({sram_we_n, sram_addr} !== {1'b0, half_addr(32'd2044, 1'b1)}) begin
            n_fail++;
            $display("FAIL reset_pre_hi: got we_n=%b addr=%h, required 0 %h", sram_we_n, sram_addr, half_addr(32'd2044, 1'b1));
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ready, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out} !== {1'b0, 1'b1, 1'b0, 18'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_hi: got ready=%b we_n=%b oe=%b addr=%h dq=%h, required 0 1 0 0 0",
                     ready, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out);
        end
        n_checks++;
        if ({WB_en_out, MEM_R_EN_out, Dest_out, ALU_result_out, Mem_read_value_out} !== 71'd0) begin
            n_fail++;
            $display("FAIL reset_mid_memwb: got wb=%b dest=%0d alu=%h, required all 0", WB_en_out, Dest_out, ALU_result_out);
        end
        MEM_Signal_in = 2'b00;
        rst = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 1", ready);
        end
        @(posedge clk); #1;
        $display("reset: checks done");
    endtask

    task automatic test_non_mem();
        run_op(1'b1, 2'b00, 5'd5, 32'h0000_1234, 32'hAAAA_5555);
        n_checks++;
        if (stall_len !== 0) begin
            n_fail++;
            $display("FAIL nonmem_stall: got %0d cycles required 0", stall_len);
        end
        n_checks++;
        if ({WB_en_out, MEM_R_EN_out, Dest_out, ALU_result_out, Mem_read_value_out} !==
            {1'b1, 1'b0, 5'd5, 32'h0000_1234, 32'd0}) begin
            n_fail++;
            $display("FAIL nonmem_out: got wb=%b mr=%b dest=%0d alu=%h rv=%h, required 1 0 5 00001234 0",
                     WB_en_out, MEM_R_EN_out, Dest_out, ALU_result_out, Mem_read_value_out);
        end
        $display("non_mem: stall=%0d alu_out=%h", stall_len, ALU_result_out);
    endtask

    // Directed store or load plus its cycle-by-cycle bus and MEM/WB checks.
    task automatic test_access(input string name, input logic [1:0] sig, input logic [4:0] dest,
                               input logic [31:0] alu, input logic [31:0] r2);
        logic [AW-1:0] ea; logic ewe, eoe; logic [15:0] edq;
        logic [31:0] exp_rv;
        int k;
        k = int'((alu - 32'(BASE)) >> 2);
        exp_rv = (sig == 2'b10) ? exp_mem[k] : 32'd0;
        run_op(1'b1, sig, dest, alu, r2);
        if (sig[0]) exp_mem[k] = r2;
        n_checks++;
        if (stall_len !== STALL || first_low !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_stall: got %0d cycles (immediate=%b), required %0d immediate", name, stall_len, first_low, STALL);
        end
        for (int c = 0; c < stall_len && c < 64; c++) begin
            model_drive(sig, alu, r2, c, ea, ewe, eoe, edq);
            n_checks++;
            if ({tr_addr[c], tr_we[c], tr_oe[c]} !== {ea, ewe, eoe} || (sig[0] && tr_dq[c] !== edq)) begin
                n_fail++;
                $display("FAIL %s_bus c%0d: got addr=%h we_n=%b oe=%b dq=%h, required %h %b %b %h",
                         name, c, tr_addr[c], tr_we[c], tr_oe[c], tr_dq[c], ea, ewe, eoe, edq);
            end
        end
        n_checks++;
        if (wr_delta !== (sig[0] ? 2 * W : 0)) begin
            n_fail++;
            $display("FAIL %s_writes: got %0d write cycles required %0d", name, wr_delta, sig[0] ? 2 * W : 0);
        end
        n_checks++;
        if ({WB_en_out, Dest_out, ALU_result_out, Mem_read_value_out} !== {1'b1, dest, alu, exp_rv} ||
            (sig != 2'b11 && MEM_R_EN_out !== sig[1])) begin
            n_fail++;
            $display("FAIL %s_out: got wb=%b mr=%b dest=%0d alu=%h rv=%h, required 1 %b %0d %h %h",
                     name, WB_en_out, MEM_R_EN_out, Dest_out, ALU_result_out, Mem_read_value_out,
                     sig[1], dest, alu, exp_rv);
        end
        $display("%s: sig=%b alu=%h stall=%0d rv=%h", name, sig, alu, stall_len, Mem_read_value_out);
    endtask

    task automatic test_back_to_back();
        int total_wr;
        int total_stall;
        test_access("b2b_load", 2'b10, 5'd12, 32'd1036, 32'd0);
        total_wr = wr_delta; total_stall = stall_len;
        test_access("b2b_store", 2'b01, 5'd13, 32'd1040, 32'h0BAD_F00D);
        total_wr += wr_delta; total_stall += stall_len;
        run_op(1'b0, 2'b00, 5'd0, 32'd0, 32'd0);
        n_checks++;
        if (total_wr !== 2 * W || total_stall !== 2 * STALL || stall_len !== 0) begin
            n_fail++;
            $display("FAIL b2b_totals: got writes=%0d stalls=%0d trailing=%0d, required %0d %0d 0",
                     total_wr, total_stall, stall_len, 2 * W, 2 * STALL);
        end
        $display("back_to_back: writes=%0d stall_cycles=%0d", total_wr, total_stall);
    endtask

    task automatic test_wrap();
        run_op(1'b0, 2'b01, 5'd1, 32'd0, 32'hCAFE_F00D);
        n_checks++;
        if (tr_addr[1] !== 18'h3FE00 || tr_addr[W + 1] !== 18'h3FE01 || stall_len !== STALL) begin
            n_fail++;
            $display("FAIL wrap_addr: got lo=%h hi=%h stall=%0d, required 3fe00 3fe01 %0d",
                     tr_addr[1], tr_addr[W + 1], stall_len, STALL);
        end
        $display("wrap: lo=%h hi=%h", tr_addr[1], tr_addr[W + 1]);
    endtask

    task automatic test_random(input int n);
        logic [1:0]  sig;
        logic [31:0] alu, r2;
        logic [4:0]  dest;
        logic        wb;
        int          k;
        logic [AW-1:0] ea; logic ewe, eoe; logic [15:0] edq;
        logic [31:0] exp_rv;
        int          bus_bad;
        for (int t = 0; t < n; t++) begin
            sig  = 2'($urandom_range(0, 3));
            k    = $urandom_range(0, 127);
            alu  = (sig == 2'b00) ? $urandom : 32'(BASE + 4 * k);
            r2   = $urandom;
            dest = 5'($urandom);
            wb   = 1'($urandom);
            exp_rv = (sig == 2'b10) ? exp_mem[k] : 32'd0;
            run_op(wb, sig, dest, alu, r2);
            if (sig[0]) exp_mem[k] = r2;
            bus_bad = 0;
            if (sig != 2'b00) begin
                for (int c = 0; c < stall_len && c < 64; c++) begin
                    model_drive(sig, alu, r2, c, ea, ewe, eoe, edq);
                    if ({tr_addr[c], tr_we[c], tr_oe[c]} !== {ea, ewe, eoe} || (sig[0] && tr_dq[c] !== edq))
                        bus_bad++;
                end
            end
            n_checks++;
            if (stall_len !== (sig == 2'b00 ? 0 : STALL) || bus_bad != 0 ||
                wr_delta !== (sig[0] ? 2 * W : 0)) begin
                n_fail++;
                $display("FAIL rand%0d_access: got stall=%0d bad_bus_cycles=%0d writes=%0d, required %0d 0 %0d",
                         t, stall_len, bus_bad, wr_delta, sig == 2'b00 ? 0 : STALL, sig[0] ? 2 * W : 0);
            end
            n_checks++;
            if ({WB_en_out, Dest_out, ALU_result_out, Mem_read_value_out} !== {wb, dest, alu, exp_rv} ||
                (sig != 2'b11 && MEM_R_EN_out !== sig[1])) begin
                n_fail++;
                $display("FAIL rand%0d_out: got wb=%b mr=%b dest=%0d alu=%h rv=%h, required %b %b %0d %h %h",
                         t, WB_en_out, MEM_R_EN_out, Dest_out, ALU_result_out, Mem_read_value_out,
                         wb, sig[1], dest, alu, exp_rv);
            end
            $display("rand%0d: sig=%b alu=%h stall=%0d rv=%h", t, sig, alu, stall_len, Mem_read_value_out);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) exp_mem[i] = init_word(i);
        test_reset();
        test_non_mem();
        test_access("store", 2'b01, 5'd7, 32'd1028, 32'hDEAD_BEEF);
        test_access("load", 2'b10, 5'd9, 32'd1028, 32'd0);
        test_back_to_back();
        test_access("both_bits", 2'b11, 5'd2, 32'd1024, 32'h0001_0002);
        test_wrap();
        test_random(40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
